// File: rtl/sram_sync_ctrl_if.sv
// Command/response bundle for sram_sync_ctrl: en/RWS command, byte-enabled write data,
// clear request, and registered read data with valid/busy/err status.
interface sram_sync_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic                  en;
  logic                  RWS;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   byte_en;
  logic                  clr;
  logic [DATA_W-1:0]     OUT;
  logic                  valid;
  logic                  busy;
  logic                  err;

  modport master (
    output en, RWS, addr, data_in, byte_en, clr,
    input  OUT, valid, busy, err
  );

  modport slave (
    input  en, RWS, addr, data_in, byte_en, clr,
    output OUT, valid, busy, err
  );
endinterface

// File: rtl/sram_sync_ctrl.sv
// Synchronous single-port SRAM with byte enables, registered read, clear sequencer and
// out-of-range flag. Define SRAM_READ_PIPE_EN to add a second output register stage.
module sram_sync_ctrl #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 10,
  parameter int unsigned       DEPTH   = 1024,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  sram_sync_ctrl_if.slave bus
);

  localparam int unsigned    NB    = DATA_W / 8;
  localparam int unsigned    CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CMP_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              clr_wr, cmd_wr;
  logic              in_range;
  logic [CNT_W-1:0]  idx;

  // Addresses at or above DEPTH are flagged rather than wrapped.
  assign in_range = CMP_W'(bus.addr) < CMP_W'(DEPTH);
  assign idx      = CNT_W'(bus.addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CLEAR);
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next state, clear counter, memory write strobes and first read stage.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_wr  = 1'b0;
    cmd_wr  = 1'b0;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_wr = 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (bus.en) begin
          if (!in_range) begin
            err_d = 1'b1;
            if (!bus.RWS) begin
              out_d   = '0;
              valid_d = 1'b1;
            end
          end else if (bus.RWS) begin
            cmd_wr = 1'b1;
          end else begin
            out_d   = mem[idx];
            valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Storage array; contents are only ever initialised by the clear sequencer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_wr) begin
        mem[cnt_q] <= CLR_VAL;
      end else if (cmd_wr) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.byte_en[i]) mem[idx][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  assign bus.busy = busy_q;

`ifdef SRAM_READ_PIPE_EN
  logic [DATA_W-1:0] out2_q;
  logic              valid2_q, err2_q;

  // Second stage keeps shifting through a clear so an in-flight read still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out2_q   <= '0;
      valid2_q <= 1'b0;
      err2_q   <= 1'b0;
    end else begin
      valid2_q <= valid_q;
      err2_q   <= err_q;
      if (valid_q) out2_q <= out_q;
    end
  end

  assign bus.OUT   = out2_q;
  assign bus.valid = valid2_q;
  assign bus.err   = err2_q;
`else
  assign bus.OUT   = out_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
`endif

endmodule

// File: doc/sram_sync_ctrl.md
Name: sram_sync_ctrl

Overview:
Parametrised synchronous single-port SRAM. It is the clocked successor to the team's 8x1024 asynchronous SRAM and keeps the same en/RWS command style (RWS=1 write, RWS=0 read). New over the old part:
- configurable width and depth,
- per-byte write enables,
- registered read with a valid strobe,
- hardware memory-clear sequencer (after reset and on request),
- out-of-range address flag.

Parameters:
DATA_W, 8, data word width in bits; must be a multiple of 8
ADDR_W, 10, address width in bits
DEPTH, 1024, number of words implemented; 1 <= DEPTH <= 2**ADDR_W
CLR_VAL, 0, value written to every word by the clear sequencer (DATA_W bits)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  command strobe; sampled each cycle
RWS  in  1  1 = write, 0 = read; qualified by en
addr  in  ADDR_W  word address
data_in  in  DATA_W  write data
byte_en  in  DATA_W/8  per-byte write enables; bit i covers data_in[8i+7:8i]
clr  in  1  request a full-memory clear
OUT  out  DATA_W  registered read data
valid  out  1  one-cycle pulse: OUT carries new read data
busy  out  1  1 while the clear sequencer runs; commands ignored
err  out  1  one-cycle pulse: last accepted command had addr >= DEPTH

Behaviour:
- Reset (rst=1 at an edge):
  - OUT=0, valid=0, err=0, clear counter=0, FSM -> CLEAR, busy=1.
  - Memory contents are not reset directly; the sequencer rewrites them.
- FSM has two states: CLEAR and IDLE.
- CLEAR state:
  - Writes CLR_VAL to word[cnt] every cycle, cnt = 0 .. DEPTH-1; takes exactly DEPTH cycles.
  - After the edge that writes word DEPTH-1: FSM -> IDLE, busy=0 (busy low on the next cycle).
  - en, clr, data_in are ignored; valid and err stay 0.
  - rst mid-clear restarts from cnt=0.
- IDLE state, priority clr > en:
  - clr=1: go to CLEAR with cnt=0, busy=1 next cycle. A simultaneous en command is dropped.
  - en=1, RWS=1, addr < DEPTH: at the edge, for each i with byte_en[i]=1, word[addr] byte i <= data_in byte i; other bytes unchanged. byte_en=0 is a legal no-op write. valid stays 0.
  - en=1, RWS=0, addr < DEPTH: OUT <= word[addr] at the edge; valid=1 for that following cycle. Read latency = 1 clock.
  - en=1, addr >= DEPTH:
    - write is discarded;
    - a read sets OUT <= 0 and valid=1;
    - err=1 for one cycle in both cases.
  - en=0: no memory access; valid=0, err=0; OUT holds its last value.
- Back-to-back commands accepted every cycle, no stall. A read in the cycle after a write to the same address returns the new data.
- OUT changes only on reads, or on reset to 0.
- Address index uses the low ADDR_W bits of addr; no wrap, out-of-range is flagged instead.

Optional Feature:
Macro SRAM_READ_PIPE_EN.
- Defined: adds a second output register stage.
  - OUT, valid and err for a read appear 2 cycles after the command edge.
  - err for a write also moves to 2 cycles, so pulses stay aligned.
  - Throughput is still 1 command per cycle.
  - Reset clears both stages; entering CLEAR does not flush the pipe, so an in-flight read still completes.
- Undefined: single stage, latency 1, as above.

Test Plan:
- Reset then wait: busy=1 for exactly DEPTH=1024 cycles, then 0. Read addr 10 -> OUT=0x00, valid pulses 1 cycle later.
- Write addr 20 data 200, byte_en=1; read addr 20 next cycle -> OUT=200 with valid 1 cycle after the read (2 with SRAM_READ_PIPE_EN).
- DATA_W=16: write 0xABCD to addr 5, then write 0x1234 with byte_en=2'b01, then read -> OUT=0xAB34.
- DEPTH=1000: write data 5 to addr 1000 -> err pulse, no store. Read addr 1000 -> OUT=0, valid=1, err=1. Read addr 999 -> CLR_VAL, err=0.
- Write 255 to addr 1023, assert clr with en=1 the same cycle -> busy rises, command dropped. After the clear, read addr 1023 -> OUT=CLR_VAL.
- Assert rst at cnt=500 of the clear -> busy stays 1 for a further 1024 cycles.
- Write/read alternating every cycle over addrs 40 and 50 (data 150, 0) -> every read returns the latest write with no stall cycles.
